// File: rtl/axonerve_kvs_axi_mem_responder.sv
// AXI4 slave memory responder: INCR write/read bursts into an internal word-addressed memory.
// Define AXONERVE_KVS_RESP_WSTRB_EN to honour s_axi_wstrb as per-byte write enables.
//
// state   | meaning
// W_IDLE  | awready high, waiting for a write burst address
// W_DATA  | wready high, accepting beats until the counter reaches zero
// W_RESP  | bvalid high until bready
// R_IDLE  | arready high, waiting for a read burst address
// R_FETCH | memory read of the current word
// R_DATA  | rvalid high, beat held until rready
module axonerve_kvs_axi_mem_responder #(
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter int C_S_AXI_DATA_WIDTH = 512,
  parameter int C_MEM_DEPTH        = 1024
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic                            err_wlast
);

  localparam int LB = $clog2(C_S_AXI_DATA_WIDTH/8);
  localparam int IW = $clog2(C_MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [0:C_MEM_DEPTH-1];
  logic [IW-1:0]                 w_idx, r_idx;
  logic [7:0]                    w_cnt, r_cnt;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic                          ready_en;
  logic                          err_q;
  logic                          aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic                          unused_bits;

  assign unused_bits = ^{s_axi_awaddr, s_axi_araddr, s_axi_wstrb};

  // ready_en keeps awready/arready low through reset and the edge that releases it
  assign s_axi_awready = ready_en && (w_state == W_IDLE);
  assign s_axi_wready  = (w_state == W_DATA);
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign s_axi_arready = ready_en && (r_state == R_IDLE);
  assign s_axi_rvalid  = (r_state == R_DATA);
  assign s_axi_rlast   = (r_state == R_DATA) && (r_cnt == 8'd0);
  assign s_axi_rdata   = rdata_q;
  assign err_wlast     = err_q;

  assign aw_fire = s_axi_awvalid && s_axi_awready;
  assign w_fire  = s_axi_wvalid  && s_axi_wready;
  assign b_fire  = s_axi_bvalid  && s_axi_bready;
  assign ar_fire = s_axi_arvalid && s_axi_arready;
  assign r_fire  = s_axi_rvalid  && s_axi_rready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state  <= W_IDLE;
      r_state  <= R_IDLE;
      ready_en <= 1'b0;
    end else begin
      w_state  <= w_next;
      r_state  <= r_next;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_fire) w_next = W_DATA;
      W_DATA:  if (w_fire && (w_cnt == 8'd0)) w_next = W_RESP;
      W_RESP:  if (b_fire) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_next = R_FETCH;
      R_FETCH: r_next = R_DATA;
      R_DATA:  if (r_fire) r_next = (r_cnt == 8'd0) ? R_IDLE : R_FETCH;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_idx <= '0;
      w_cnt <= 8'd0;
      err_q <= 1'b0;
    end else if (aw_fire) begin
      w_idx <= s_axi_awaddr[LB +: IW];
      w_cnt <= s_axi_awlen;
    end else if (w_fire) begin
      w_idx <= w_idx + 1'b1;
      w_cnt <= w_cnt - 8'd1;
      // the beat counter, not wlast, ends the burst; a disagreement is only flagged
      if (s_axi_wlast != (w_cnt == 8'd0)) err_q <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_idx   <= '0;
      r_cnt   <= 8'd0;
      rdata_q <= '0;
    end else begin
      if (ar_fire) begin
        r_idx <= s_axi_araddr[LB +: IW];
        r_cnt <= s_axi_arlen;
      end else if (r_fire && (r_cnt != 8'd0)) begin
        r_idx <= r_idx + 1'b1;
        r_cnt <= r_cnt - 8'd1;
      end
      if (r_state == R_FETCH) rdata_q <= mem[r_idx];
    end
  end

  // unreset storage; non-blocking update gives read-first behaviour on a same-word collision
  always_ff @(posedge aclk) begin
    if (w_fire) begin
`ifdef AXONERVE_KVS_RESP_WSTRB_EN
      for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
`else
      mem[w_idx] <= s_axi_wdata;
`endif
    end
  end

endmodule

// File: tb/tb_axonerve_kvs_axi_mem_responder.sv
// Directed bench for axonerve_kvs_axi_mem_responder: model memory feeds a read-data scoreboard.
// Expectations for the strobe test follow AXONERVE_KVS_RESP_WSTRB_EN.
module tb_axonerve_kvs_axi_mem_responder;

  localparam int AW = 64;
  localparam int DW = 512;
  localparam int DEPTH = 1024;
  localparam int SW = DW/8;
  localparam int LB = 6;
  localparam int TMO = 50;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
  logic          arvalid = 1'b0, rready = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [7:0]    awlen = 8'd0, arlen = 8'd0;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid, rlast, err_wlast;
  logic [DW-1:0] rdata;

  logic [DW-1:0] model_mem [0:DEPTH-1];
  logic [DW-1:0] exp_q [$];
  logic          exp_last_q [$];
  int            total = 0;
  int            bad = 0;

  always #5 aclk = ~aclk;

  axonerve_kvs_axi_mem_responder #(
    .C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(DW), .C_MEM_DEPTH(DEPTH)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wlast(wlast), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rlast(rlast),
    .err_wlast(err_wlast)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input int i, input logic [DW-1:0] d, input logic [SW-1:0] s);
`ifdef AXONERVE_KVS_RESP_WSTRB_EN
    for (int k = 0; k < SW; k++) if (s[k]) model_mem[i][k*8 +: 8] = d[k*8 +: 8];
`else
    model_mem[i] = d;
`endif
  endtask

  task automatic aw_hs(input logic [AW-1:0] a, input logic [7:0] len);
    int n = 0;
    @(negedge aclk);
    awvalid = 1'b1; awaddr = a; awlen = len;
    while (!awready && n < TMO) begin @(negedge aclk); n++; end
    if (n >= TMO) chk("aw_timeout", awready, 1);
    @(posedge aclk); @(negedge aclk);
    awvalid = 1'b0;
    chk("wready_after_aw", wready, 1);
    chk("awready_busy", awready, 0);
  endtask

  task automatic ar_hs(input logic [AW-1:0] a, input logic [7:0] len);
    int n = 0;
    @(negedge aclk);
    arvalid = 1'b1; araddr = a; arlen = len;
    while (!arready && n < TMO) begin @(negedge aclk); n++; end
    if (n >= TMO) chk("ar_timeout", arready, 1);
    @(posedge aclk); @(negedge aclk);
    arvalid = 1'b0;
    chk("rvalid_t1", rvalid, 0);
    chk("arready_busy", arready, 0);
  endtask

  // bad_beat: index of a beat whose wlast is inverted (-1 for none)
  task automatic wr_burst(input logic [AW-1:0] a, input int len, input logic [DW-1:0] base,
                          input logic [SW-1:0] s, input int bad_beat, input int hold_b);
    int idx = int'(a[LB +: 10]);
    aw_hs(a, 8'(len));
    for (int b = 0; b <= len; b++) begin
      int n = 0;
      wvalid = 1'b1; wdata = base + DW'(b); wstrb = s;
      wlast = (b == len) ^ (b == bad_beat);
      while (!wready && n < TMO) begin @(negedge aclk); n++; end
      if (n >= TMO) chk("w_timeout", wready, 1);
      @(posedge aclk);
      model_write(idx, wdata, s);
      idx = (idx + 1) % DEPTH;
      @(negedge aclk);
      if (b == bad_beat) chk("err_wlast_set", err_wlast, 1);
      if (b < len) chk("wready_mid_burst", wready, 1);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_after_last_w", bvalid, 1);
    for (int h = 0; h < hold_b; h++) begin
      @(negedge aclk);
      chk("bvalid_held", bvalid, 1);
      chk("awready_low_during_b", awready, 0);
    end
    bready = 1'b1;
    @(posedge aclk); @(negedge aclk);
    bready = 1'b0;
    chk("bvalid_cleared", bvalid, 0);
    chk("awready_after_b", awready, 1);
  endtask

  task automatic rd_burst(input logic [AW-1:0] a, input int len, input bit toggle);
    int idx = int'(a[LB +: 10]);
    int beats = 0;
    int n = 0;
    for (int b = 0; b <= len; b++) begin
      exp_q.push_back(model_mem[(idx + b) % DEPTH]);
      exp_last_q.push_back(b == len);
    end
    ar_hs(a, 8'(len));
    @(posedge aclk); @(negedge aclk);
    chk("rvalid_t2", rvalid, 1);
    while (beats <= len && n < 4*TMO) begin
      rready = toggle ? n[0] : 1'b1;
      if (rvalid) begin
        chk("rdata", rdata, exp_q[0]);
        chk("rlast", rlast, exp_last_q[0]);
        chk("arready_low_during_r", arready, 0);
        if (rready) begin
          void'(exp_q.pop_front());
          void'(exp_last_q.pop_front());
          beats++;
        end
      end
      @(posedge aclk); @(negedge aclk);
      n++;
    end
    rready = 1'b0;
    if (beats <= len) chk("r_timeout", beats, len + 1);
    chk("arready_after_r", arready, 1);
    chk("rvalid_after_r", rvalid, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awready"}, awready, 0);
    chk({tag, "_wready"}, wready, 0);
    chk({tag, "_bvalid"}, bvalid, 0);
    chk({tag, "_arready"}, arready, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_rlast"}, rlast, 0);
    chk({tag, "_err_wlast"}, err_wlast, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  task automatic release_reset();
    awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("awready_after_reset", awready, 1);
    chk("arready_after_reset", arready, 1);
  endtask

  initial begin
    logic [DW-1:0] strobe_exp;
    repeat (3) @(negedge aclk);
    chk_all_zero("reset");
    release_reset();

    // 4-beat burst and readback
    wr_burst(64'h0, 3, DW'('hA0), '1, -1, 0);
    chk("err_wlast_clean", err_wlast, 0);
    rd_burst(64'h0, 3, 1'b0);

    // wrap from the last word to word 0
    wr_burst(64'(DEPTH-1) << LB, 1, DW'('hB0), '1, -1, 0);
    rd_burst(64'h0, 0, 1'b0);
    chk("wrap_model_word0", model_mem[0], DW'('hB1));
    rd_burst(64'(DEPTH-1) << LB, 1, 1'b0);

    // back-pressure on B and R
    wr_burst(64'(10) << LB, 2, DW'('hC0), '1, -1, 5);
    rd_burst(64'(10) << LB, 2, 1'b1);

    // early wlast: burst still ends on the counter and the error sticks
    wr_burst(64'(20) << LB, 1, DW'('hD0), '1, 0, 0);
    wr_burst(64'(22) << LB, 0, DW'('hE0), '1, -1, 0);
    chk("err_wlast_sticky", err_wlast, 1);
    rd_burst(64'(20) << LB, 2, 1'b0);

    // strobe handling
    wr_burst(64'(30) << LB, 0, '1, '1, -1, 0);
    wr_burst(64'(30) << LB, 0, '0, SW'(1), -1, 0);
`ifdef AXONERVE_KVS_RESP_WSTRB_EN
    strobe_exp = {{(DW-8){1'b1}}, 8'h00};
`else
    strobe_exp = '0;
`endif
    chk("strobe_model", model_mem[30], strobe_exp);
    rd_burst(64'(30) << LB, 0, 1'b0);

    // reset during a write burst
    aw_hs(64'(40) << LB, 8'd3);
    wvalid = 1'b1; wdata = DW'('h55); wstrb = '1; wlast = 1'b0;
    @(posedge aclk);
    model_write(40, DW'('h55), '1);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    chk_all_zero("reset_mid_write");
    release_reset();
    chk("bvalid_none_after_reset", bvalid, 0);
    wr_burst(64'(40) << LB, 1, DW'('hF0), '1, -1, 0);
    rd_burst(64'(40) << LB, 1, 1'b0);

    // reset during a read burst
    ar_hs(64'(40) << LB, 8'd1);
    @(posedge aclk); @(negedge aclk);
    chk("rvalid_before_reset", rvalid, 1);
    aresetn = 1'b0;
    #1;
    chk_all_zero("reset_mid_read");
    release_reset();
    chk("rvalid_none_after_reset", rvalid, 0);
    rd_burst(64'(40) << LB, 1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
